// File: rtl/sap_pkg.sv
// Shared definitions for the SAP core: opcodes, T-state encoding and the ALU helper.
package sap_pkg;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_STA = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JZ  = 4'd5;
    localparam logic [3:0] OP_JC  = 4'd6;
    localparam logic [3:0] OP_LDI = 4'd7;
    localparam logic [3:0] OP_OUT = 4'd14;
    localparam logic [3:0] OP_HLT = 4'd15;

    typedef enum logic [2:0] {
        T1 = 3'd0,
        T2 = 3'd1,
        T3 = 3'd2,
        T4 = 3'd3,
        T5 = 3'd4,
        T6 = 3'd5
    } tstate_e;

    localparam int unsigned ALU_MAX_W = 32;

    // Returns {carry, result} in bits [w:0]; for subtraction the carry means no borrow (a >= b).
    function automatic logic [ALU_MAX_W:0] alu_calc(input logic [ALU_MAX_W-1:0] a,
                                                    input logic [ALU_MAX_W-1:0] b,
                                                    input logic sub,
                                                    input int unsigned w);
        logic [ALU_MAX_W:0] mask;
        logic [ALU_MAX_W:0] bb;
        logic [ALU_MAX_W:0] r;
        mask = ((ALU_MAX_W+1)'(1) << w) - (ALU_MAX_W+1)'(1);
        bb   = sub ? (~{1'b0, b} & mask) : {1'b0, b};
        r    = {1'b0, a} + bb + (ALU_MAX_W+1)'(sub);
        return r & ((mask << 1) | (ALU_MAX_W+1)'(1));
    endfunction

endpackage

// File: rtl/sap_core_if.sv
// Front-panel and display-side signal bundle of the SAP core.
interface sap_core_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
);
    logic              run;
    logic              step;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic [DATA_W-1:0] dbg_data;
    logic [DATA_W-1:0] obus;
    logic              out_valid;
    logic [2:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              halted;
    logic              flag_z;
    logic              flag_c;

    modport master (
        output run, step, prog_we, prog_addr, prog_data,
        input  dbg_data, obus, out_valid, state, pc, halted, flag_z, flag_c
    );

    modport slave (
        input  run, step, prog_we, prog_addr, prog_data,
        output dbg_data, obus, out_valid, state, pc, halted, flag_z, flag_c
    );
endinterface

// File: rtl/sap_ram.sv
// Program RAM: asynchronous read by MAR, synchronous write, registered debug read port.
module sap_ram #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [Depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        dbg_data <= mem[dbg_addr];
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/sap_core.sv
// SAP processor core: six-T-state control FSM, datapath and program RAM on one clock.
// Optional: define SAP_COND_JUMP_EN to enable JZ/JC (otherwise they decode as NOP).
module sap_core
    import sap_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned OP_W   = 4
) (
    input logic       clk,
    input logic       CLR,
    sap_core_if.slave bus
);
    if (OP_W + ADDR_W != DATA_W || OP_W < 4 || DATA_W > ALU_MAX_W) begin : g_param_check
        $error("sap_core: illegal DATA_W/ADDR_W/OP_W combination");
    end

    tstate_e           state_q, state_d;
    logic [ADDR_W-1:0] pc_q, mar_q;
    logic [DATA_W-1:0] ir_q, a_q, b_q, obus_q;
    logic              out_valid_q, halted_q, z_q, c_q;

    logic              tick;
    logic [OP_W-1:0]   op;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] mem_rd;
    logic [DATA_W:0]   alu_res;
    logic              core_we, prog_ok, ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    assign tick    = (bus.run | bus.step) & ~halted_q & ~CLR;
    assign op      = ir_q[DATA_W-1 -: OP_W];
    assign operand = ir_q[ADDR_W-1:0];
    assign alu_res = (DATA_W+1)'(alu_calc(ALU_MAX_W'(a_q), ALU_MAX_W'(b_q),
                                          op == OP_W'(OP_SUB), DATA_W));

    // Core STA write takes priority over the front-panel program port.
    assign core_we   = tick && state_q == T5 && op == OP_W'(OP_STA);
    assign prog_ok   = bus.prog_we && !bus.run && (halted_q || state_q == T1) && !CLR;
    assign ram_we    = core_we | prog_ok;
    assign ram_waddr = core_we ? mar_q : bus.prog_addr;
    assign ram_wdata = core_we ? a_q : bus.prog_data;

    sap_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_ram (
        .clk      (clk),
        .we       (ram_we),
        .waddr    (ram_waddr),
        .wdata    (ram_wdata),
        .raddr    (mar_q),
        .rdata    (mem_rd),
        .dbg_addr (bus.prog_addr),
        .dbg_data (bus.dbg_data)
    );

    always_comb begin
        state_d = state_q;
        if (tick) begin
            if (state_q == T4 && op == OP_W'(OP_HLT)) begin
                state_d = T4;
            end else if (state_q == T6) begin
                state_d = T1;
            end else begin
                state_d = tstate_e'(state_q + 3'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            state_q <= T1;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (CLR) begin
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            obus_q      <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            z_q         <= 1'b0;
            c_q         <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            if (tick) begin
                case (state_q)
                    T1: mar_q <= pc_q;
                    T2: pc_q  <= pc_q + ADDR_W'(1);
                    T3: ir_q  <= mem_rd;
                    T4: begin
                        case (op)
                            OP_W'(OP_LDA), OP_W'(OP_ADD), OP_W'(OP_SUB), OP_W'(OP_STA):
                                mar_q <= operand;
                            OP_W'(OP_JMP): pc_q <= operand;
`ifdef SAP_COND_JUMP_EN
                            OP_W'(OP_JZ):  if (z_q) pc_q <= operand;
                            OP_W'(OP_JC):  if (c_q) pc_q <= operand;
`endif
                            OP_W'(OP_LDI): a_q <= DATA_W'(operand);
                            OP_W'(OP_OUT): begin
                                obus_q      <= a_q;
                                out_valid_q <= 1'b1;
                            end
                            OP_W'(OP_HLT): halted_q <= 1'b1;
                            default: ;
                        endcase
                    end
                    T5: begin
                        if (op == OP_W'(OP_LDA)) begin
                            a_q <= mem_rd;
                        end else if (op == OP_W'(OP_ADD) || op == OP_W'(OP_SUB)) begin
                            b_q <= mem_rd;
                        end
                    end
                    T6: begin
                        if (op == OP_W'(OP_ADD) || op == OP_W'(OP_SUB)) begin
                            {c_q, a_q} <= alu_res;
                            z_q        <= (alu_res[DATA_W-1:0] == '0);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.obus      = obus_q;
    assign bus.out_valid = out_valid_q;
    assign bus.state     = state_q;
    assign bus.pc        = pc_q;
    assign bus.halted    = halted_q;
    assign bus.flag_z    = z_q;
    assign bus.flag_c    = c_q;
endmodule

// File: tb/tb_sap_core.sv
// Directed self-checking bench for sap_core with hand-computed expectations.
module tb_sap_core;
    logic clk = 1'b0;
    logic clr;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    sap_core_if #(.DATA_W(8), .ADDR_W(4)) bus ();

    sap_core #(
        .DATA_W(8),
        .ADDR_W(4),
        .OP_W  (4)
    ) dut (
        .clk (clk),
        .CLR (clr),
        .bus (bus.slave)
    );

    task automatic do_reset();
        bus.run     = 1'b0;
        bus.step    = 1'b0;
        bus.prog_we = 1'b0;
        clr         = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic write_mem(input logic [3:0] addr, input logic [7:0] data);
        bus.prog_addr = addr;
        bus.prog_data = data;
        bus.prog_we   = 1'b1;
        @(negedge clk);
        bus.prog_we   = 1'b0;
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 16; i++) write_mem(4'(i), 8'h80);
    endtask

    task automatic run_until_halt(input int budget, output bit ok);
        ok      = 1'b0;
        bus.run = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.halted) begin
                ok = 1'b1;
                break;
            end
        end
        bus.run = 1'b0;
    endtask

    task automatic pulse_step();
        bus.step = 1'b1;
        @(negedge clk);
        bus.step = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr     = 1'b0;
        bus.run = 1'b1;
        repeat (7) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.pc !== 4'h0) begin
            n_fail++; $display("FAIL reset_pc: got %h expected 0", bus.pc);
        end
        n_checks++;
        if (bus.state !== 3'd0) begin
            n_fail++; $display("FAIL reset_state: got %0d expected 0", bus.state);
        end
        n_checks++;
        if ({bus.halted, bus.flag_z, bus.flag_c, bus.out_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got h/z/c/ov=%b expected 0000",
                     {bus.halted, bus.flag_z, bus.flag_c, bus.out_valid});
        end
        n_checks++;
        if (bus.obus !== 8'h00) begin
            n_fail++; $display("FAIL reset_obus: got %h expected 00", bus.obus);
        end
        bus.run = 1'b0;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_add_out();
        int pulses = 0;
        do_reset();
        fill_nop();
        write_mem(4'h0, 8'h09);
        write_mem(4'h1, 8'h1A);
        write_mem(4'h2, 8'hE0);
        write_mem(4'h3, 8'hF0);
        write_mem(4'h9, 8'h05);
        write_mem(4'hA, 8'h03);
        bus.run = 1'b1;
        repeat (24) begin
            @(negedge clk);
            if (bus.out_valid) pulses++;
        end
        bus.run = 1'b0;
        n_checks++;
        if (pulses != 1) begin
            n_fail++; $display("FAIL add_out_valid_pulses: got %0d expected 1", pulses);
        end
        n_checks++;
        if (bus.obus !== 8'h08) begin
            n_fail++; $display("FAIL add_obus: got %h expected 08", bus.obus);
        end
        n_checks++;
        if ({bus.halted, bus.flag_c, bus.flag_z} !== 3'b100) begin
            n_fail++;
            $display("FAIL add_halt_flags: got h/c/z=%b expected 100",
                     {bus.halted, bus.flag_c, bus.flag_z});
        end
        n_checks++;
        if (bus.pc !== 4'h4 || bus.state !== 3'd3) begin
            n_fail++;
            $display("FAIL add_pc_state: got pc=%h state=%0d expected pc=4 state=3",
                     bus.pc, bus.state);
        end
    endtask

    task automatic test_sub_wrap();
        bit ok;
        do_reset();
        fill_nop();
        write_mem(4'h0, 8'h72);
        write_mem(4'h1, 8'h25);
        write_mem(4'h2, 8'hE0);
        write_mem(4'h3, 8'hF0);
        write_mem(4'h5, 8'h03);
        run_until_halt(100, ok);
        n_checks++;
        if (!ok || bus.obus !== 8'hFF) begin
            n_fail++; $display("FAIL sub_wrap_result: got %h halted=%b expected FF", bus.obus, ok);
        end
        n_checks++;
        if ({bus.flag_c, bus.flag_z} !== 2'b00) begin
            n_fail++;
            $display("FAIL sub_wrap_flags: got c/z=%b expected 00", {bus.flag_c, bus.flag_z});
        end
        do_reset();
        write_mem(4'h0, 8'h73);
        run_until_halt(100, ok);
        n_checks++;
        if (!ok || bus.obus !== 8'h00) begin
            n_fail++; $display("FAIL sub_equal_result: got %h halted=%b expected 00", bus.obus, ok);
        end
        n_checks++;
        if ({bus.flag_c, bus.flag_z} !== 2'b11) begin
            n_fail++;
            $display("FAIL sub_equal_flags: got c/z=%b expected 11", {bus.flag_c, bus.flag_z});
        end
    endtask

    task automatic test_loop();
        bit ok;
        do_reset();
        fill_nop();
        write_mem(4'h0, 8'h73);
        write_mem(4'h1, 8'h2F);
        write_mem(4'h2, 8'h55);
        write_mem(4'h3, 8'h41);
        write_mem(4'h5, 8'hF0);
        write_mem(4'hF, 8'h01);
`ifdef SAP_COND_JUMP_EN
        run_until_halt(300, ok);
        n_checks++;
        if (!ok) begin
            n_fail++; $display("FAIL loop_halt: got halted=0 expected 1 within 300 clks");
        end
        n_checks++;
        if (bus.pc !== 4'h6) begin
            n_fail++; $display("FAIL loop_pc: got %h expected 6", bus.pc);
        end
        n_checks++;
        if ({bus.flag_z, bus.flag_c} !== 2'b11) begin
            n_fail++;
            $display("FAIL loop_flags: got z/c=%b expected 11", {bus.flag_z, bus.flag_c});
        end
`else
        ok      = 1'b0;
        bus.run = 1'b1;
        repeat (300) begin
            @(negedge clk);
            if (bus.halted) ok = 1'b1;
        end
        bus.run = 1'b0;
        n_checks++;
        if (ok) begin
            n_fail++; $display("FAIL loop_no_cond_jump: got halted=1 expected 0");
        end
`endif
    endtask

    task automatic test_sta_dbg();
        bit ok;
        do_reset();
        fill_nop();
        write_mem(4'h0, 8'h77);
        write_mem(4'h1, 8'h38);
        write_mem(4'h2, 8'hF0);
        run_until_halt(100, ok);
        bus.prog_addr = 4'h8;
        repeat (2) @(negedge clk);
        n_checks++;
        if (!ok || bus.dbg_data !== 8'h07) begin
            n_fail++; $display("FAIL sta_dbg: got %h halted=%b expected 07", bus.dbg_data, ok);
        end
        do_reset();
        write_mem(4'h0, 8'h40);
        bus.run = 1'b1;
        @(negedge clk);
        bus.prog_addr = 4'h8;
        bus.prog_data = 8'hAA;
        bus.prog_we   = 1'b1;
        repeat (12) @(negedge clk);
        bus.prog_we = 1'b0;
        @(negedge clk);
        bus.run = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.dbg_data !== 8'h07) begin
            n_fail++; $display("FAIL prog_we_while_run: got %h expected 07", bus.dbg_data);
        end
    endtask

    task automatic test_step();
        do_reset();
        fill_nop();
        for (int i = 0; i < 6; i++) begin
            pulse_step();
            n_checks++;
            if (bus.state !== 3'((i + 1) % 6)) begin
                n_fail++;
                $display("FAIL step_state_%0d: got %0d expected %0d", i, bus.state, (i + 1) % 6);
            end
        end
        n_checks++;
        if (bus.pc !== 4'h1) begin
            n_fail++; $display("FAIL step_pc: got %h expected 1", bus.pc);
        end
    endtask

    task automatic test_clr_mid();
        bit ok;
        do_reset();
        fill_nop();
        write_mem(4'h0, 8'h75);
        write_mem(4'h1, 8'h1F);
        write_mem(4'h2, 8'h1F);
        write_mem(4'hF, 8'hFF);
        repeat (12) pulse_step();
        n_checks++;
        if ({bus.flag_c, bus.flag_z} !== 2'b10) begin
            n_fail++;
            $display("FAIL clr_pre_flags: got c/z=%b expected 10", {bus.flag_c, bus.flag_z});
        end
        repeat (4) pulse_step();
        n_checks++;
        if (bus.state !== 3'd4) begin
            n_fail++; $display("FAIL clr_pre_state: got %0d expected 4", bus.state);
        end
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_checks++;
        if (bus.state !== 3'd0 || bus.pc !== 4'h0 || {bus.flag_c, bus.flag_z} !== 2'b00) begin
            n_fail++;
            $display("FAIL clr_mid_regs: got state=%0d pc=%h c/z=%b expected 0 0 00",
                     bus.state, bus.pc, {bus.flag_c, bus.flag_z});
        end
        bus.prog_addr = 4'h2;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.dbg_data !== 8'h1F) begin
            n_fail++; $display("FAIL clr_ram_intact: got %h expected 1F", bus.dbg_data);
        end
        // A cleared to 0 makes ADD F produce FF with no carry.
        write_mem(4'h0, 8'h1F);
        write_mem(4'h1, 8'hE0);
        write_mem(4'h2, 8'hF0);
        run_until_halt(100, ok);
        n_checks++;
        if (!ok || bus.obus !== 8'hFF || bus.flag_c !== 1'b0) begin
            n_fail++;
            $display("FAIL clr_a_cleared: got obus=%h c=%b halted=%b expected FF 0 1",
                     bus.obus, bus.flag_c, ok);
        end
    endtask

    task automatic test_pc_wrap();
        do_reset();
        fill_nop();
        bus.run = 1'b1;
        repeat (91) @(negedge clk);
        n_checks++;
        if (bus.pc !== 4'hF) begin
            n_fail++; $display("FAIL pc_before_wrap: got %h expected F", bus.pc);
        end
        @(negedge clk);
        n_checks++;
        if (bus.pc !== 4'h0) begin
            n_fail++; $display("FAIL pc_wrap: got %h expected 0", bus.pc);
        end
        bus.run = 1'b0;
    endtask

    initial begin
        clr           = 1'b1;
        bus.run       = 1'b0;
        bus.step      = 1'b0;
        bus.prog_we   = 1'b0;
        bus.prog_addr = '0;
        bus.prog_data = '0;
        repeat (2) @(negedge clk);
        test_reset();
        test_add_out();
        test_sub_wrap();
        test_loop();
        test_sta_dbg();
        test_step();
        test_clr_mid();
        test_pc_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sap_core.md
Name: sap_core

Overview:
- Parametrised next-generation SAP processor core. Merges program counter, instruction register, accumulator, B register, ALU, output register and program RAM into one synchronous block.
- Driven by a single board clock with a clock-enable tick, replacing the derived CLK/nCLK scheme.
- Adds STA, JMP, conditional jumps, LDI, Z/C flags and wider data/address paths.
- Sits under the board top level: front-panel input logic feeds run/step/program controls; the output register feeds the seven-segment driver.

Parameters:
- DATA_W, 8: accumulator, B, output register and memory word width.
- ADDR_W, 4: PC/MAR width; RAM depth is 2**ADDR_W.
- OP_W, 4: opcode field width. Instruction word = {opcode, operand}. Elaboration error unless OP_W+ADDR_W == DATA_W and OP_W >= 4.

Ports:
- clk  in  1  board clock; all state on its rising edge.
- CLR  in  1  synchronous active-high reset.
- run  in  1  level; 1 = free-run, one T-state per clk.
- step  in  1  single-cycle pulse, already debounced; advances one T-state when run=0.
- prog_we  in  1  program write strobe.
- prog_addr  in  ADDR_W  program/debug address.
- prog_data  in  DATA_W  program write data.
- dbg_data  out  DATA_W  mem[prog_addr], registered, 1-cycle latency.
- obus  out  DATA_W  output register.
- out_valid  out  1  1-cycle pulse when obus is loaded.
- state  out  3  current T-state, 0..5 = T1..T6.
- pc  out  ADDR_W  program counter.
- halted  out  1  HLT executed.
- flag_z  out  1  zero flag.
- flag_c  out  1  carry/no-borrow flag.

Behaviour:
- Reset (CLR=1, dominates all inputs): pc, MAR, IR, A, B, obus, flags, halted, out_valid = 0; state=T1. RAM contents and dbg_data unaffected. Legal mid-instruction; a partial instruction is abandoned with no side effect.
- tick = (run | step) & ~halted & ~CLR. Without tick, all core registers hold.
- state advances T1..T6 on each tick, then wraps to T1. Every instruction takes 6 ticks; unused T-states are NOPs.
- RAM: read is combinational by MAR. Write is synchronous.
- Fetch:
  - T1: MAR<=pc.
  - T2: pc<=pc+1, mod 2**ADDR_W; wraps to 0.
  - T3: IR<=mem[MAR].
- Execute, op = IR opcode, operand = IR low ADDR_W bits:
  - 0 LDA: T4 MAR<=operand; T5 A<=mem[MAR].
  - 1 ADD: T4 MAR<=operand; T5 B<=mem[MAR]; T6 {C,A}<=A+B; Z<=(A+B result==0).
  - 2 SUB: as ADD, T6 A<=A-B mod 2**DATA_W; C<=(A>=B); Z updated.
  - 3 STA: T4 MAR<=operand; T5 mem[MAR]<=A.
  - 4 JMP: T4 pc<=operand.
  - 5 JZ: T4 pc<=operand if Z.
  - 6 JC: T4 pc<=operand if C.
  - 7 LDI: T4 A<=operand zero-extended. Flags unchanged.
  - 8-13: NOP.
  - 14 OUT: T4 obus<=A; out_valid=1 for that clk only.
  - 15 HLT: T4 halted<=1. state stays at T4 until CLR.
- Flags change only on ADD/SUB.
- Program port:
  - prog_we takes effect only when run=0 and (halted or state==T1); otherwise ignored.
  - A simultaneous STA write and prog_we cannot occur (STA requires a tick at T5). If both would target the same cycle, the core write wins.
- dbg_data: registered mem[prog_addr] every clk, regardless of run. Reflects a write one cycle after it.
- step while run=1: no extra effect, still one T-state per clk.

Optional Feature:
- SAP_COND_JUMP_EN:
  - Defined: JZ/JC behave as above.
  - Undefined: opcodes 5/6 decode as NOP. Flags are still computed and output.

Decomposition:
- Package sap_pkg holds:
  - opcode localparams (OP_LDA..OP_HLT);
  - T-state enum (T1..T6, 3-bit);
  - function computing the ALU result and carry for a given width.
- One sub-module, sap_ram: 2**ADDR_W x DATA_W RAM with async read, sync write, registered debug read port.
- Control FSM and datapath stay in sap_core.

Test Plan:
- Program {0:LDA 9, 1:ADD A, 2:OUT, 3:HLT, 9:0x05, A:0x03}, run=1 -> obus=0x08, one out_valid pulse, halted=1, C=0, Z=0, 24 clks after run rises.
- SUB wrap: A=0x02, B=0x03 -> A=0xFF, C=0, Z=0. A=0x03, B=0x03 -> A=0x00, C=1, Z=1.
- Loop: LDI 3; SUB F (mem[F]=1); JZ 5; JMP 1; HLT at 5 -> halts with A=0, pc=6. Without SAP_COND_JUMP_EN, runs forever and halted stays 0.
- STA 8 after LDI 7 -> dbg_data=0x07 with prog_addr=8. prog_we while run=1 -> RAM unchanged.
- Step mode: run=0, 6 step pulses -> state sequences 0..5 then back to 0, pc=1. CLR at state=4 of ADD -> A, flags, pc = 0, state=0, RAM intact.
- PC wrap: JMP-free program of 16 NOPs -> pc returns to 0 after the 16th fetch.
